fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage feeding decode: holds the program counter, issues one 16-bit instruction read at a time to a variable-latency instruction memory, and presents the fetched instruction with its PC and PC+2 until decode accepts it. It applies redirects (branch/jump targets resolved downstream), squashes stale in-flight fetches, stops fetching after an accepted HALT, and flags memory timeouts.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- MAX_WAIT, 255, max cycles in WAIT before timeout error (1..255)
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (sampled at posedge clk)
- imem_req  out  1  read request, high only in FETCH state
- imem_addr  out  16  read address, equals pc
- imem_rdy  in  1  read data valid for the single outstanding request
- imem_data  in  16  read data, valid when imem_rdy
- stall  in  1  decode cannot accept this cycle
- redirect_en  in  1  load redirect_pc, discard current/outstanding fetch
- redirect_pc  in  16  redirect target
- instruction  out  16  fetched instruction to decode
- pc_out  out  16  address of instruction
- pc_plus2  out  16  pc_out + 2 (mod 2^16), for JAL/JALR link
- inst_valid  out  1  instruction/pc_out valid
- halted  out  1  HALT accepted; fetch stopped
- err  out  1  sticky error (misaligned redirect or memory timeout)

## Operation
- Reset: pc=RESET_PC, state=FETCH, instruction=16'h0800 (NOP), pc_out=0, inst_valid=0, halted=0, err=0, squash=0, wait counter=0. imem_req=0 while rst low.
- States: FETCH, WAIT, HOLD, HALTED.
- FETCH: imem_req=1, imem_addr=pc, one cycle -> WAIT; wait counter cleared.
- WAIT: imem_req=0; counter increments each cycle without imem_rdy.
  - imem_rdy and squash=0: instruction<=imem_data, pc_out<=pc, pc<=pc+2, -> HOLD.
  - imem_rdy and squash=1: data dropped, squash<=0, -> FETCH.
  - counter reaches MAX_WAIT without imem_rdy: err<=1, -> HALTED.
- HOLD: inst_valid=1; outputs stable while stall=1. stall=0: if instruction[15:11]==5'b00000 (HALT) -> HALTED, else -> FETCH.
- HALTED: inst_valid=0, imem_req=0, halted=1, pc frozen; exits only on reset.
- Redirect (any state except HALTED; priority over stall, imem_rdy, timeout):
  - pc<={redirect_pc[15:1],1'b0}; redirect_pc[0]=1 sets err (execution continues).
  - FETCH: request already issued -> WAIT with squash=1.
  - WAIT without imem_rdy: squash<=1, stay WAIT (counter cleared).
  - WAIT with imem_rdy: data dropped -> FETCH, squash=0.
  - HOLD: held instruction dropped (inst_valid 0 next cycle, including a held HALT) -> FETCH.
  - Redirect in HALTED ignored.
- PC arithmetic 16-bit, wraps 16'hFFFE -> 16'h0000 without error; pc_plus2 wraps likewise.
- err sticky until reset.

## Timing
- All outputs registered or derived from state; no combinational path from stall/imem_rdy/redirect to imem_req or inst_valid.
- Unstalled, zero-wait memory: FETCH at N, imem_rdy at N+1, inst_valid N+2..accept, next FETCH N+3; peak throughput 1 instruction / 3 cycles.
- Redirect at cycle N in HOLD: inst_valid=0 at N+1, imem_req=1 with imem_addr=target at N+1.
- HALT accepted at N: halted=1, inst_valid=0 from N+1.
- Reset asserted mid-WAIT: next cycle is FETCH at RESET_PC; a late imem_rdy for the pre-reset request arriving while in FETCH is ignored (memory contract: reset clears the outstanding request).
- Timeout: MAX_WAIT cycles in WAIT without imem_rdy -> err=1, halted=1 the following cycle.

## Test plan
- Reset release, memory returns 16'h4000,16'h4020 with 1-cycle latency, stall=0 -> pc_out 0x0000 then 0x0002, pc_plus2 0x0002/0x0004, inst_valid one cycle each, imem_addr 0,2,4.
- Stall held 5 cycles in HOLD -> instruction/pc_out/inst_valid constant, imem_req stays 0; release -> FETCH next cycle at pc+2.
- Redirect to 0x0100 during WAIT (memory latency 4) -> stale data dropped, inst_valid never asserted for it, next imem_addr 0x0100, returned instruction shown with pc_out 0x0100.
- Redirect to 0x0101 -> err=1, imem_addr 0x0100, fetching continues.
- Memory returns 16'h0000 (HALT), stall=0 -> halted=1, inst_valid=0, imem_req never reasserts; later redirect ignored; rst low one cycle -> fetch restarts at RESET_PC, halted=0, err=0.
- MAX_WAIT=4, imem_rdy never asserted -> err=1 and halted=1 after 4 WAIT cycles; PC at 0xFFFE fetch -> next pc 0x0000, no err.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues one read at a time to a
// variable-latency instruction memory and holds the result until decode takes it.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [15:0] redirect_pc,
   output logic [15:0] instruction,
   output logic [15:0] pc_out,
   output logic [15:0] pc_plus2,
   output logic        inst_valid,
   output logic        halted,
   output logic        err
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALTED} state_e;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
   localparam logic [15:0] NOP = 16'h0800;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] inst_q, inst_d;
   logic [15:0] pco_q, pco_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        squash_q, squash_d;
   logic        err_q, err_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      pco_d    = pco_q;
      cnt_d    = cnt_q;
      squash_d = squash_q;
      err_d    = err_q;
      case (state_q)
         S_FETCH: begin
            state_d  = S_WAIT;
            cnt_d    = 8'd0;
            // The request to the old PC is already out; its data must be dropped.
            squash_d = redirect_en;
         end
         S_WAIT: begin
            if (redirect_en) begin
               cnt_d = 8'd0;
               if (imem_rdy) begin
                  state_d  = S_FETCH;
                  squash_d = 1'b0;
               end else begin
                  squash_d = 1'b1;
               end
            end else if (imem_rdy) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = S_FETCH;
               end else begin
                  inst_d  = imem_data;
                  pco_d   = pc_q;
                  pc_d    = pc_q + 16'd2;
                  state_d = S_HOLD;
               end
            end else if (cnt_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = S_HALTED;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (redirect_en)
               state_d = S_FETCH;
            else if (!stall)
               state_d = (inst_q[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
         end
         default: ;
      endcase
      // Redirect overrides whatever PC update the state logic chose.
      if (redirect_en && state_q != S_HALTED) begin
         pc_d = {redirect_pc[15:1], 1'b0};
         if (redirect_pc[0])
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         inst_q   <= NOP;
         pco_q    <= 16'h0000;
         cnt_q    <= 8'd0;
         squash_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         pco_q    <= pco_d;
         cnt_q    <= cnt_d;
         squash_q <= squash_d;
         err_q    <= err_d;
      end
   end

   assign imem_req    = rst && (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instruction = inst_q;
   assign pc_out      = pco_q;
   assign pc_plus2    = pco_q + 16'd2;
   assign inst_valid  = (state_q == S_HOLD);
   assign halted      = (state_q == S_HALTED);
   assign err         = err_q;

endmodule
